// File: rtl/smallseg_g0table_port_arbiter_pkg.sv
// Shared definitions for the small-segment/G0 rule table slice.
// Covers the entry and address widths, the update op codes, the arbiter
// state encoding and the bit offsets of the fields inside a 171-bit entry.
package smallseg_pkg;

  localparam int unsigned ENTRY_W = 171;
  localparam int unsigned ADDR_W  = 11;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'b00,
    OP_DELETE = 2'b01,
    OP_CLEAR  = 2'b10,
    OP_RSVD   = 2'b11
  } upd_op_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } arb_state_t;

  // Entry layout, LSB first. An all-zero entry marks an invalid rule.
  localparam int unsigned F_SRCIP_LO    = 0;    // 32b source IP
  localparam int unsigned F_SRCIP_W     = 32;
  localparam int unsigned F_LENGTHS_LO  = 32;   // 2 x 6b prefix lengths
  localparam int unsigned F_LENGTHS_W   = 12;
  localparam int unsigned F_PORTS_LO    = 44;   // 4 x 16b port range bounds
  localparam int unsigned F_PORTS_W     = 64;
  localparam int unsigned F_PROTO_LO    = 108;  // 8b value + 8b mask
  localparam int unsigned F_PROTO_W     = 16;
  localparam int unsigned F_WILDCARD_LO = 124;
  localparam int unsigned F_WILDCARD_W  = 8;
  localparam int unsigned F_RULEID_LO   = 132;
  localparam int unsigned F_RULEID_W    = 32;
  localparam int unsigned F_INDEX_LO    = 164;
  localparam int unsigned F_INDEX_W     = 7;

endpackage

// File: rtl/smallseg_g0table_port_arbiter_if.sv
// Bundle of the lookup, update and RAM-port signals around one table arbiter.
//   slave  : arbiter side (takes requests and ram_dout, drives readies,
//            responses and the RAM port)
//   master : requesters plus the RAM instance
interface smallseg_g0table_port_arbiter_if #(
  parameter int unsigned TAG_W = 4
);
  import smallseg_pkg::*;

  logic                lk_valid;
  logic                lk_ready;
  logic [ADDR_W-1:0]   lk_addr;
  logic [TAG_W-1:0]    lk_tag;
  logic                rsp_valid;
  logic [ENTRY_W-1:0]  rsp_data;
  logic [TAG_W-1:0]    rsp_tag;
  logic                rsp_err;
  logic                upd_valid;
  logic                upd_ready;
  logic [1:0]          upd_op;
  logic [ADDR_W-1:0]   upd_addr;
  logic [ENTRY_W-1:0]  upd_data;
  logic                upd_done;
  logic                upd_err;
  logic                busy;
  logic [ADDR_W-1:0]   ram_addr;
  logic [ENTRY_W-1:0]  ram_din;
  logic                ram_we;
  logic [ENTRY_W-1:0]  ram_dout;

  modport slave (
    input  lk_valid, lk_addr, lk_tag,
    input  upd_valid, upd_op, upd_addr, upd_data,
    input  ram_dout,
    output lk_ready, rsp_valid, rsp_data, rsp_tag, rsp_err,
    output upd_ready, upd_done, upd_err, busy,
    output ram_addr, ram_din, ram_we
  );

  modport master (
    output lk_valid, lk_addr, lk_tag,
    output upd_valid, upd_op, upd_addr, upd_data,
    output ram_dout,
    input  lk_ready, rsp_valid, rsp_data, rsp_tag, rsp_err,
    input  upd_ready, upd_done, upd_err, busy,
    input  ram_addr, ram_din, ram_we
  );

endinterface

// File: rtl/smallseg_g0table_port_arbiter.sv
// Owner of the single read/write port of one small-segment/G0 rule table RAM.
// Lookups have priority; a pending update is forced through after
// STARVE_LIMIT consecutive lookup grants. CLEAR sweeps every address with
// zeros while both requesters are held off.
//   clk, rst : clock, synchronous active-high reset
//   bus      : lookup request/response, update request/completion,
//              busy flag and the RAM port (ram_dout is registered read data)
module smallseg_g0table_port_arbiter
  import smallseg_pkg::*;
#(
  parameter int unsigned TABLE_ENTRY_SIZE = 1738,
  parameter int unsigned STARVE_LIMIT     = 8,
  parameter int unsigned TAG_W            = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  smallseg_g0table_port_arbiter_if.slave  bus
);

  localparam int unsigned STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDR_W-1:0]   LAST_ADDR  = ADDR_W'(TABLE_ENTRY_SIZE);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  arb_state_t          r_state;
  logic [STARVE_W-1:0] r_starve_cnt;
  logic [ADDR_W-1:0]   r_clr_cnt;
  logic                r_rsp_valid;
  logic                r_rsp_err;
  logic [TAG_W-1:0]    r_rsp_tag;
  logic                r_upd_done;
  logic                r_upd_err;

  upd_op_t w_op;
  logic    w_idle;
  logic    w_starved;
  logic    w_lk_ready;
  logic    w_upd_ready;
  logic    w_lk_gnt;
  logic    w_upd_gnt;
  logic    w_lk_oor;
  logic    w_upd_oor;
  logic    w_upd_bad;
  logic    w_upd_wr;
  logic    w_clr_start;
  logic    w_clr_last;

  assign w_op        = upd_op_t'(bus.upd_op);
  assign w_idle      = (r_state == ST_IDLE);
  assign w_starved   = (r_starve_cnt == STARVE_MAX);
  assign w_upd_ready = !rst && w_idle && (!bus.lk_valid || w_starved);
  assign w_lk_ready  = !rst && w_idle && !(bus.upd_valid && w_starved);
  assign w_lk_gnt    = bus.lk_valid && w_lk_ready;
  assign w_upd_gnt   = bus.upd_valid && w_upd_ready;

  assign w_lk_oor    = (bus.lk_addr > LAST_ADDR);
  assign w_upd_oor   = (bus.upd_addr > LAST_ADDR);
  assign w_upd_bad   = (w_op == OP_RSVD) ||
                       (((w_op == OP_WRITE) || (w_op == OP_DELETE)) && w_upd_oor);
  assign w_upd_wr    = w_upd_gnt && ((w_op == OP_WRITE) || (w_op == OP_DELETE)) && !w_upd_oor;
  assign w_clr_start = w_upd_gnt && (w_op == OP_CLEAR);
  assign w_clr_last  = (r_state == ST_CLEAR) && (r_clr_cnt == LAST_ADDR);

  assign bus.lk_ready  = w_lk_ready;
  assign bus.upd_ready = w_upd_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_tag   = r_rsp_tag;
  assign bus.rsp_data  = (r_rsp_valid && !r_rsp_err) ? bus.ram_dout : '0;
  assign bus.upd_done  = r_upd_done;
  assign bus.upd_err   = r_upd_err;
  assign bus.busy      = (r_state == ST_CLEAR);

  // RAM port mux. The sweep write is gated by rst so a reset landing mid-CLEAR
  // leaves the current sweep address untouched.
  always_comb begin
    bus.ram_we   = 1'b0;
    bus.ram_addr = '0;
    bus.ram_din  = '0;
    if (r_state == ST_CLEAR) begin
      bus.ram_we   = !rst;
      bus.ram_addr = r_clr_cnt;
    end else if (w_lk_gnt) begin
      bus.ram_addr = w_lk_oor ? '0 : bus.lk_addr;
    end else if (w_upd_wr) begin
      bus.ram_we   = 1'b1;
      bus.ram_addr = bus.upd_addr;
      bus.ram_din  = (w_op == OP_WRITE) ? bus.upd_data : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_starve_cnt <= '0;
      r_clr_cnt    <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_tag    <= '0;
      r_upd_done   <= 1'b0;
      r_upd_err    <= 1'b0;
    end else begin
      r_rsp_valid <= w_lk_gnt;
      r_rsp_err   <= w_lk_gnt && w_lk_oor;
      if (w_lk_gnt) begin
        r_rsp_tag <= bus.lk_tag;
      end

      r_upd_done <= (w_upd_gnt && !w_clr_start) || w_clr_last;
      r_upd_err  <= w_upd_gnt && w_upd_bad;

      // Any update grant (including CLEAR entry) or an idle update side
      // restarts the fairness window.
      if (w_upd_gnt || !bus.upd_valid) begin
        r_starve_cnt <= '0;
      end else if (w_lk_gnt && !w_starved) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end

      unique case (r_state)
        ST_IDLE: begin
          if (w_clr_start) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
          end
        end
        ST_CLEAR: begin
          if (w_clr_last) begin
            r_state   <= ST_IDLE;
            r_clr_cnt <= '0;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_smallseg_g0table_port_arbiter.sv
module tb_smallseg_g0table_port_arbiter;
  import smallseg_pkg::*;

  localparam int unsigned TES = 1738;
  localparam int unsigned SL  = 8;
  localparam int unsigned TW  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  smallseg_g0table_port_arbiter_if #(.TAG_W(TW)) bus ();

  smallseg_g0table_port_arbiter #(
    .TABLE_ENTRY_SIZE(TES),
    .STARVE_LIMIT(SL),
    .TAG_W(TW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // RAM instance the parent would place beside the arbiter: registered read,
  // read-before-write.
  logic [170:0] mem [0:TES];
  always @(posedge clk) begin
    if (bus.ram_we && bus.ram_addr <= 11'(TES)) mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= (bus.ram_addr <= 11'(TES)) ? mem[bus.ram_addr] : '0;
  end

  // Reference view of the table contents, maintained from the ops issued.
  logic [170:0] model [0:TES];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [170:0] obs, input logic [170:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [170:0] rand_entry();
    logic [170:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) r = {r[138:0], $urandom()};
    return r | 171'd1;
  endfunction

  function automatic logic [170:0] exp_data(input logic [10:0] a);
    return (a > 11'(TES)) ? 171'd0 : model[a];
  endfunction

  task automatic do_lookup(input logic [10:0] a, input logic [3:0] t);
    bus.lk_valid = 1'b1;
    bus.lk_addr  = a;
    bus.lk_tag   = t;
    #3;
    check("lk_ready", bus.lk_ready, 1'b1);
    check("lk_ram_we", bus.ram_we, 1'b0);
    check("lk_ram_addr", bus.ram_addr, (a > 11'(TES)) ? 11'd0 : a);
    tick();
    bus.lk_valid = 1'b0;
    #3;
    check("rsp_valid", bus.rsp_valid, 1'b1);
    check("rsp_tag", bus.rsp_tag, t);
    check("rsp_err", bus.rsp_err, a > 11'(TES));
    check("rsp_data", bus.rsp_data, exp_data(a));
    tick();
  endtask

  task automatic do_upd(input logic [1:0] op, input logic [10:0] a, input logic [170:0] d);
    logic bad;
    logic wr;
    bad = (op == 2'b11) || (op < 2'b10 && a > 11'(TES));
    wr  = (op < 2'b10) && !bad;
    bus.upd_valid = 1'b1;
    bus.upd_op    = op;
    bus.upd_addr  = a;
    bus.upd_data  = d;
    #3;
    check("upd_ready", bus.upd_ready, 1'b1);
    check("upd_ram_we", bus.ram_we, wr);
    if (wr) begin
      check("upd_ram_addr", bus.ram_addr, a);
      check("upd_ram_din", bus.ram_din, (op == 2'b00) ? d : 171'd0);
    end
    tick();
    bus.upd_valid = 1'b0;
    if (wr) model[a] = (op == 2'b00) ? d : 171'd0;
    #3;
    check("upd_done", bus.upd_done, 1'b1);
    check("upd_err", bus.upd_err, bad);
    check("upd_no_extra_we", bus.ram_we, 1'b0);
    tick();
  endtask

  task automatic lookup_burst(input int n);
    logic       have_prev;
    logic [10:0] pa;
    logic [3:0]  pt;
    have_prev = 1'b0;
    pa = '0;
    pt = '0;
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        bus.lk_valid = 1'b1;
        bus.lk_addr  = 11'($urandom_range(0, 2047));
        bus.lk_tag   = 4'($urandom());
      end else begin
        bus.lk_valid = 1'b0;
      end
      #3;
      if (i < n) begin
        check("burst_ready", bus.lk_ready, 1'b1);
        check("burst_addr", bus.ram_addr, (bus.lk_addr > 11'(TES)) ? 11'd0 : bus.lk_addr);
      end
      if (have_prev) begin
        check("burst_rsp_valid", bus.rsp_valid, 1'b1);
        check("burst_rsp_tag", bus.rsp_tag, pt);
        check("burst_rsp_err", bus.rsp_err, pa > 11'(TES));
        check("burst_rsp_data", bus.rsp_data, exp_data(pa));
      end
      have_prev = (i < n);
      pa = bus.lk_addr;
      pt = bus.lk_tag;
      tick();
    end
  endtask

  initial begin
    logic [10:0]  sa;
    logic [170:0] sd;
    int           sweep_bad;

    bus.lk_valid  = 1'b1;
    bus.lk_addr   = '0;
    bus.lk_tag    = '0;
    bus.upd_valid = 1'b1;
    bus.upd_op    = 2'b00;
    bus.upd_addr  = 11'd3;
    bus.upd_data  = '0;

    // Reset: both requesters asserted, nothing may be granted.
    repeat (3) @(posedge clk);
    #4;
    check("rst_lk_ready", bus.lk_ready, 1'b0);
    check("rst_upd_ready", bus.upd_ready, 1'b0);
    check("rst_ram_we", bus.ram_we, 1'b0);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_tag", bus.rsp_tag, 4'd0);
    check("rst_rsp_err", bus.rsp_err, 1'b0);
    check("rst_rsp_data", bus.rsp_data, 171'd0);
    check("rst_upd_done", bus.upd_done, 1'b0);
    check("rst_upd_err", bus.upd_err, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    tick();
    rst = 1'b0;
    bus.lk_valid  = 1'b0;
    bus.upd_valid = 1'b0;
    #3;
    check("idle_ram_addr", bus.ram_addr, 11'd0);
    check("idle_ram_we", bus.ram_we, 1'b0);
    tick();

    // Fill the whole table through the port, one write per cycle.
    for (int unsigned a = 0; a <= TES; a++) begin
      sd = rand_entry();
      bus.upd_valid = 1'b1;
      bus.upd_op    = 2'b00;
      bus.upd_addr  = 11'(a);
      bus.upd_data  = sd;
      model[a]      = sd;
      tick();
    end
    bus.upd_valid = 1'b0;
    tick();

    do_upd(2'b00, 11'd5, 171'hABC);
    do_lookup(11'd5, 4'd3);
    do_lookup(11'd2000, 4'd9);
    lookup_burst(40);

    // WRITE to the last address, then a lookup of it the very next cycle.
    bus.upd_valid = 1'b1;
    bus.upd_op    = 2'b00;
    bus.upd_addr  = 11'(TES);
    bus.upd_data  = 171'h1F;
    #3;
    check("wlast_ram_we", bus.ram_we, 1'b1);
    check("wlast_ram_addr", bus.ram_addr, 11'(TES));
    tick();
    model[TES] = 171'h1F;
    bus.upd_valid = 1'b0;
    bus.lk_valid  = 1'b1;
    bus.lk_addr   = 11'(TES);
    bus.lk_tag    = 4'd7;
    #3;
    check("wlast_done", bus.upd_done, 1'b1);
    check("wlast_lk_ready", bus.lk_ready, 1'b1);
    tick();
    bus.lk_valid = 1'b0;
    #3;
    check("wlast_rsp_data", bus.rsp_data, 171'h1F);
    check("wlast_rsp_tag", bus.rsp_tag, 4'd7);
    tick();

    // Random writes/deletes, including bad addresses and the reserved op.
    for (int i = 0; i < 16; i++) begin
      do_upd(2'($urandom_range(0, 1)), 11'($urandom_range(0, 1800)), rand_entry());
    end
    do_upd(2'b00, 11'(TES + 1), rand_entry());
    do_upd(2'b11, 11'd10, rand_entry());
    lookup_burst(40);

    // Starvation bound: lookups held, update raised at cycle M.
    sa = 11'($urandom_range(0, TES));
    sd = rand_entry();
    bus.lk_valid = 1'b1;
    for (int unsigned i = 0; i <= SL + 1; i++) begin
      if (i == 0) begin
        bus.upd_valid = 1'b1;
        bus.upd_op    = 2'b00;
        bus.upd_addr  = sa;
        bus.upd_data  = sd;
      end
      if (i == SL + 1) bus.upd_valid = 1'b0;
      bus.lk_addr = 11'($urandom_range(0, TES));
      bus.lk_tag  = 4'($urandom());
      #3;
      check("starve_lk_ready", bus.lk_ready, i != SL);
      check("starve_upd_ready", bus.upd_ready, i == SL);
      check("starve_ram_we", bus.ram_we, i == SL);
      check("starve_rsp_valid", bus.rsp_valid, (i >= 1) && (i != SL + 1));
      check("starve_upd_done", bus.upd_done, i == SL + 1);
      tick();
    end
    bus.lk_valid = 1'b0;
    model[sa] = sd;
    tick();
    do_lookup(sa, 4'd5);

    // Full CLEAR sweep with a lookup waiting the whole time.
    bus.upd_valid = 1'b1;
    bus.upd_op    = 2'b10;
    #3;
    check("clr_upd_ready", bus.upd_ready, 1'b1);
    check("clr_grant_no_we", bus.ram_we, 1'b0);
    tick();
    bus.upd_valid = 1'b0;
    bus.lk_valid  = 1'b1;
    bus.lk_addr   = 11'd0;
    bus.lk_tag    = 4'd2;
    sweep_bad = 0;
    for (int unsigned k = 0; k <= TES; k++) begin
      #3;
      if (bus.ram_we !== 1'b1 || bus.ram_addr !== 11'(k) || bus.ram_din !== 171'd0 ||
          bus.lk_ready !== 1'b0 || bus.upd_ready !== 1'b0 || bus.busy !== 1'b1 ||
          bus.upd_done !== 1'b0) sweep_bad++;
      tick();
    end
    check("clr_sweep_bad_cycles", 171'(sweep_bad), 171'd0);
    for (int unsigned a = 0; a <= TES; a++) model[a] = '0;
    #3;
    check("clr_done", bus.upd_done, 1'b1);
    check("clr_err", bus.upd_err, 1'b0);
    check("clr_busy_fall", bus.busy, 1'b0);
    check("clr_lk_resume", bus.lk_ready, 1'b1);
    check("clr_post_we", bus.ram_we, 1'b0);
    tick();
    bus.lk_valid = 1'b0;
    #3;
    check("clr_rsp0_valid", bus.rsp_valid, 1'b1);
    check("clr_rsp0_data", bus.rsp_data, 171'd0);
    tick();
    do_lookup(11'd900, 4'd1);
    do_lookup(11'(TES), 4'd4);

    // Reset in the middle of a CLEAR sweep.
    for (int unsigned a = 0; a <= 120; a++) begin
      do_upd(2'b00, 11'(a), rand_entry());
    end
    bus.upd_valid = 1'b1;
    bus.upd_op    = 2'b10;
    tick();
    bus.upd_valid = 1'b0;
    repeat (100) tick();
    rst = 1'b1;
    #3;
    check("rstclr_busy_before", bus.busy, 1'b1);
    check("rstclr_we_in_rst", bus.ram_we, 1'b0);
    tick();
    #3;
    check("rstclr_ram_we", bus.ram_we, 1'b0);
    check("rstclr_busy", bus.busy, 1'b0);
    check("rstclr_upd_done", bus.upd_done, 1'b0);
    tick();
    rst = 1'b0;
    for (int unsigned a = 0; a < 100; a++) model[a] = '0;
    #3;
    check("rstclr_upd_done_after", bus.upd_done, 1'b0);
    tick();
    do_lookup(11'd0, 4'd6);
    do_lookup(11'd99, 4'd8);
    do_lookup(11'd100, 4'd10);
    do_lookup(11'd101, 4'd11);
    lookup_burst(30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
